// File: rtl/sys_ctrl_pkg.sv
// Shared system-controller definitions: response-scheduler FSM states,
// source IDs and per-source response byte counts.
package sys_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEND    = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_CKSUM   = 3'd4
  } tx_state_e;

  localparam int SRC_REG = 0;
  localparam int SRC_ALU = 1;

  localparam logic [1:0] REG_RESP_BYTES = 2'd1;
  localparam logic [1:0] ALU_RESP_BYTES = 2'd2;

endpackage

// File: rtl/rr_arb2.sv
// 2-way round-robin arbiter. The pointer only moves when both sources
// contend, so a lone requester never steals the other's turn.
module rr_arb2
  import sys_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr;  // 0: REG has priority, 1: ALU has priority

  always_comb begin
    gnt = req;
    if (&req) gnt = ptr ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               ptr <= 1'b0;
    else if (advance && &req) ptr <= gnt[SRC_REG];
  end

endmodule

// File: rtl/tx_resp_sched.sv
// Shares the UART TX byte channel between the REG read path (1 byte) and the
// ALU result path (2 bytes). Define TX_RESP_CHECKSUM_EN to append an XOR byte.
module tx_resp_sched
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ALU_OUT_WIDTH = 2*DATA_WIDTH
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
  input  logic                     OUT_Valid,
  input  logic [DATA_WIDTH-1:0]    RdData,
  input  logic                     RdData_Valid,
  output logic                     alu_ready,
  output logic                     reg_ready,
  output logic [DATA_WIDTH-1:0]    TX_P_DATA,
  output logic                     TX_D_VLD,
  input  logic                     busy,
  output logic                     drop_pulse
);

  tx_state_e state, state_nx;

  logic                     alu_full, reg_full;
  logic [ALU_OUT_WIDTH-1:0] alu_q, shbuf;
  logic [DATA_WIDTH-1:0]    reg_q;
  logic [1:0]               cnt;
  logic [1:0]               req, gnt;
  logic                     grant, send_data, alu_take, reg_take;
`ifdef TX_RESP_CHECKSUM_EN
  logic                     send_ck, ck_done;
  logic [DATA_WIDTH-1:0]    ck;
`endif

  // bit position equals source ID
  assign req   = {alu_full, reg_full};
  assign grant = (state == ST_IDLE) && (|req);

  rr_arb2 u_arb (
    .clk     (CLK),
    .rst_n   (RST),
    .req     (req),
    .advance (grant),
    .gnt     (gnt)
  );

  // a slot being granted this cycle counts as free for capture
  assign alu_take  = OUT_Valid    && (!alu_full || (grant && gnt[SRC_ALU]));
  assign reg_take  = RdData_Valid && (!reg_full || (grant && gnt[SRC_REG]));
  assign alu_ready = !alu_full;
  assign reg_ready = !reg_full;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    send_data = 1'b0;
`ifdef TX_RESP_CHECKSUM_EN
    send_ck   = 1'b0;
`endif
    case (state)
      ST_IDLE:    if (|req) state_nx = ST_SEND;
      ST_SEND:    if (!busy) begin
                    send_data = 1'b1;
                    state_nx  = ST_WAIT_HI;
                  end
      ST_WAIT_HI: if (busy) state_nx = ST_WAIT_LO;
      ST_WAIT_LO: if (!busy) begin
                    if (cnt != 2'd0)  state_nx = ST_SEND;
`ifdef TX_RESP_CHECKSUM_EN
                    else if (!ck_done) state_nx = ST_CKSUM;
`endif
                    else              state_nx = ST_IDLE;
                  end
`ifdef TX_RESP_CHECKSUM_EN
      ST_CKSUM:   if (!busy) begin
                    send_ck  = 1'b1;
                    state_nx = ST_WAIT_HI;
                  end
`endif
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      alu_full   <= 1'b0;
      reg_full   <= 1'b0;
      alu_q      <= '0;
      reg_q      <= '0;
      shbuf      <= '0;
      cnt        <= '0;
      TX_P_DATA  <= '0;
      TX_D_VLD   <= 1'b0;
      drop_pulse <= 1'b0;
`ifdef TX_RESP_CHECKSUM_EN
      ck         <= '0;
      ck_done    <= 1'b0;
`endif
    end else begin
      drop_pulse <= (OUT_Valid && !alu_take) || (RdData_Valid && !reg_take);
`ifdef TX_RESP_CHECKSUM_EN
      TX_D_VLD   <= send_data | send_ck;
`else
      TX_D_VLD   <= send_data;
`endif

      if (alu_take) begin
        alu_q    <= ALU_OUT;
        alu_full <= 1'b1;
      end else if (grant && gnt[SRC_ALU]) alu_full <= 1'b0;

      if (reg_take) begin
        reg_q    <= RdData;
        reg_full <= 1'b1;
      end else if (grant && gnt[SRC_REG]) reg_full <= 1'b0;

      if (grant) begin
        shbuf <= gnt[SRC_ALU] ? alu_q : {{(ALU_OUT_WIDTH-DATA_WIDTH){1'b0}}, reg_q};
        cnt   <= gnt[SRC_ALU] ? ALU_RESP_BYTES : REG_RESP_BYTES;
`ifdef TX_RESP_CHECKSUM_EN
        ck      <= '0;
        ck_done <= 1'b0;
`endif
      end else if (send_data) begin
        // low byte first; buffer shifts down for the next one
        TX_P_DATA <= shbuf[DATA_WIDTH-1:0];
        shbuf     <= shbuf >> DATA_WIDTH;
        cnt       <= cnt - 2'd1;
`ifdef TX_RESP_CHECKSUM_EN
        ck        <= ck ^ shbuf[DATA_WIDTH-1:0];
      end else if (send_ck) begin
        TX_P_DATA <= ck;
        ck_done   <= 1'b1;
`endif
      end
    end
  end

endmodule
